// File: rtl/rseq_ctrl.sv
// Two-requester sign-magnitude remainder unit: round-robin grant, repeated-subtraction
// remainder, and a registered result held until the consumer takes it.
module rseq_ctrl #(
  parameter int MAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [MAG_W:0]   req0_a,
  input  logic [MAG_W:0]   req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [MAG_W:0]   req1_a,
  input  logic [MAG_W:0]   req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [MAG_W+1:0] res,
  output logic             res_id,
  output logic             zer_f,
  output logic             neg_f,
  output logic             dz_f,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a request, one ready offered to the granted requester
  // CALC  | subtracting |b| from the remainder until it drops below |b|
  // DONE  | result presented, held until res_ready
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic               r_last;
  logic               r_a_sign;
  logic [MAG_W-1:0]   r_b_mag;
  logic [MAG_W-1:0]   r_rem;
  logic               r_id;
  logic [MAG_W+1:0]   r_res;
  logic               r_zer;
  logic               r_neg;
  logic               r_dz;
  logic               r_res_valid;
  logic               r_busy;
  logic               w_idle;
  logic               w_gnt1;
  logic               w_acc0;
  logic               w_acc1;
  logic               w_sign;
  logic               w_unused_bsign;

  // r_last holds the requester granted most recently; reset value 1 lets req0 win first
  assign w_idle     = (r_state == IDLE);
  assign w_gnt1     = req1_valid & (~req0_valid | ~r_last);
  assign req0_ready = rst_n & w_idle & req0_valid & ~w_gnt1;
  assign req1_ready = rst_n & w_idle & w_gnt1;
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_sign     = r_a_sign & (r_rem != '0);

  // divisor sign plays no part in a remainder
  assign w_unused_bsign = req0_b[MAG_W] ^ req1_b[MAG_W];

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (w_acc0 | w_acc1) w_nxt = CALC;
      CALC: if ((r_b_mag == '0) || (r_rem < r_b_mag)) w_nxt = DONE;
      DONE: if (res_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_a_sign    <= 1'b0;
      r_b_mag     <= '0;
      r_rem       <= '0;
      r_id        <= 1'b0;
      r_res       <= '0;
      r_zer       <= 1'b0;
      r_neg       <= 1'b0;
      r_dz        <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_res_valid <= (w_nxt == DONE);
      r_busy      <= (w_nxt != IDLE);
      if (w_idle && w_acc0) begin
        r_last   <= 1'b0;
        r_id     <= 1'b0;
        r_a_sign <= req0_a[MAG_W];
        r_rem    <= req0_a[MAG_W-1:0];
        r_b_mag  <= req0_b[MAG_W-1:0];
      end else if (w_idle && w_acc1) begin
        r_last   <= 1'b1;
        r_id     <= 1'b1;
        r_a_sign <= req1_a[MAG_W];
        r_rem    <= req1_a[MAG_W-1:0];
        r_b_mag  <= req1_b[MAG_W-1:0];
      end else if (r_state == CALC) begin
        if (r_b_mag == '0) begin
          r_res <= '0;
          r_zer <= 1'b0;
          r_neg <= 1'b0;
          r_dz  <= 1'b1;
        end else if (r_rem >= r_b_mag) begin
          r_rem <= r_rem - r_b_mag;
        end else begin
          r_res <= {w_sign, 1'b0, r_rem};
          r_zer <= (r_rem == '0);
          r_neg <= w_sign;
          r_dz  <= 1'b0;
        end
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res       = r_res;
  assign res_id    = r_id;
  assign zer_f     = r_zer;
  assign neg_f     = r_neg;
  assign dz_f      = r_dz;
  assign busy      = r_busy;

endmodule
